axil_slave_regfile: RTL and testbench

- Parametrised AXI4-Lite slave that terminates all five channels (AW, W, B, AR, R) into an internal register file of NUM_REGS words.
- Independent write and read state machines run concurrently.
- Supports byte-lane strobes, out-of-range decode with SLVERR, and AW/W arrival in any order.
- Sits behind the AXI4-Lite master channel blocks as the generic peripheral-register endpoint.

---
 rtl/axil_slave_regfile.sv | 192 +++++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave terminating AW/W/B/AR/R into a NUM_REGS-word register file.
// Write and read engines are independent two-state machines.
module axil_slave_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [1:0]                BRESP,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [2:0]                ARPROT,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_nx;
  rstate_t rstate, rstate_nx;

  logic                  live;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs, w_hs, b_hs;
  logic                  ar_hs, r_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  w_ok, r_ok;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  unused_ok;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // Held beats take priority; otherwise use the beat handshaking now.
  assign c_addr = aw_held ? aw_addr : AWADDR;
  assign c_data = w_held ? w_data : WDATA;
  assign c_strb = w_held ? w_strb : WSTRB;

  assign commit = (wstate == W_IDLE)
                & (aw_held | aw_hs)
                & (w_held | w_hs);

  assign w_idx = c_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign r_idx = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_ok  = {1'b0, w_idx} < (IDX_W+1)'(NUM_REGS);
  assign r_ok  = {1'b0, r_idx} < (IDX_W+1)'(NUM_REGS);

  assign unused_ok = ^{AWPROT, ARPROT,
                       c_addr[ADDR_LSB-1:0],
                       ARADDR[ADDR_LSB-1:0]};

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) live <= 1'b0;
    else          live <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nx;
      rstate <= rstate_nx;
    end
  end

  always_comb begin
    wstate_nx = wstate;
    unique case (1'b1)
      (wstate == W_IDLE): if (commit) wstate_nx = W_RESP;
      (wstate == W_RESP): if (b_hs)   wstate_nx = W_IDLE;
      default: ;
    endcase
  end

  always_comb begin
    rstate_nx = rstate;
    unique case (1'b1)
      (rstate == R_IDLE): if (ar_hs) rstate_nx = R_DATA;
      (rstate == R_DATA): if (r_hs)  rstate_nx = R_IDLE;
      default: ;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    if (wstate == W_IDLE) begin
      AWREADY = live & ~aw_held;
      WREADY  = live & ~w_held;
    end else begin
      BVALID  = 1'b1;
    end
    if (rstate == R_IDLE) ARREADY = live;
    else                  RVALID  = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= AWADDR;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && w_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    r_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_idx == IDX_W'(i)) r_word = regs[i];
    end
  end

  // Response payloads are captured once and held until the handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      BRESP <= 2'b00;
      RDATA <= '0;
      RRESP <= 2'b00;
    end else begin
      if (commit) BRESP <= w_ok ? 2'b00 : 2'b10;
      if (ar_hs) begin
        RDATA <= r_ok ? r_word : '0;
        RRESP <= r_ok ? 2'b00 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Randomised self-checking bench for axil_slave_regfile.
// Reference model: a plain array of words updated by byte strobes.
module tb_axil_slave_regfile;

  logic        ACLK;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [31:0] model [16];

  axil_slave_regfile #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY),
    .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < 16;
  endfunction

  function automatic void model_wr(input logic [31:0] a,
                                   input logic [31:0] d,
                                   input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (in_rng(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (in_rng(a)) return model[int'(a >> 2)];
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic do_aw_w(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int aw_dly,
                         input int w_dly, output int cyc, output bit to);
    bit aw_done, w_done, aw_f, w_f;
    aw_done = 0; w_done = 0; cyc = 0; to = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done)) begin
      if (cyc >= 50) begin to = 1; break; end
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_f) aw_done = 1;
      if (w_f)  w_done = 1;
    end
    AWVALID = 0; WVALID = 0;
  endtask

  task automatic wait_b(output logic [1:0] r, output int w, output bit to);
    w = 0; to = 0; BREADY = 1;
    while (BVALID !== 1'b1) begin
      if (w >= 50) begin to = 1; break; end
      @(negedge ACLK);
      w++;
    end
    r = BRESP;
    if (!to) @(negedge ACLK);
  endtask

  task automatic do_ar(input logic [31:0] a, input int dly,
                       output int cyc, output bit to);
    bit f;
    f = 0; cyc = 0; to = 0; ARADDR = a;
    while (!f) begin
      if (cyc >= 50) begin to = 1; break; end
      ARVALID = (cyc >= dly);
      f = ARVALID && ARREADY;
      @(negedge ACLK);
      cyc++;
    end
    ARVALID = 0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r,
                        output int w, output bit to);
    w = 0; to = 0; RREADY = 1;
    while (RVALID !== 1'b1) begin
      if (w >= 50) begin to = 1; break; end
      @(negedge ACLK);
      w++;
    end
    d = RDATA; r = RRESP;
    if (!to) @(negedge ACLK);
  endtask

  task automatic test_reset;
    logic [40:0] outs;
    repeat (3) @(negedge ACLK);
    outs = {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA};
    checks++;
    if (outs !== 41'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    ARESETn = 1;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 000",
               {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_edge: got %b expected 111",
               {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic;
    int c, w; bit to, to2;
    logic [1:0] r; logic [31:0] d;
    do_aw_w(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, c, to);
    model_wr(32'h04, 32'hDEADBEEF, 4'hF);
    wait_b(r, w, to2);
    checks++;
    if (to || to2 || c != 1 || w != 0) begin
      errors++;
      $display("FAIL basic_b_latency: got cyc=%0d wait=%0d expected 1/0", c, w);
    end
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("FAIL basic_bresp: got %b expected 00", r);
    end
    do_ar(32'h04, 0, c, to);
    wait_r(d, r, w, to2);
    checks++;
    if (to || to2 || w != 0) begin
      errors++;
      $display("FAIL basic_r_latency: got wait=%0d expected 0", w);
    end
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("FAIL basic_read: got %h/%b expected deadbeef/00", d, r);
    end
  endtask

  task automatic test_w_first;
    int c, w; bit to, to2;
    logic [1:0] r; logic [31:0] d;
    AWADDR = 32'h08; WDATA = 32'h11223344; WSTRB = 4'hF;
    WVALID = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      WVALID = 0;
      checks++;
      if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
        errors++;
        $display("FAIL w_first_hold: got wr=%b bv=%b awr=%b expected 0/0/1",
                 WREADY, BVALID, AWREADY);
      end
    end
    AWVALID = 1;
    @(negedge ACLK);
    AWVALID = 0;
    model_wr(32'h08, 32'h11223344, 4'hF);
    checks++;
    if (BVALID !== 1'b1) begin
      errors++;
      $display("FAIL w_first_commit: got bvalid=%b expected 1", BVALID);
    end
    wait_b(r, w, to);
    do_aw_w(32'h08, 32'hAABBCCDD, 4'h2, 1, 0, c, to);
    model_wr(32'h08, 32'hAABBCCDD, 4'h2);
    wait_b(r, w, to2);
    checks++;
    if (to || to2 || r !== 2'b00) begin
      errors++;
      $display("FAIL strobe_bresp: got %b expected 00", r);
    end
    do_ar(32'h08, 0, c, to);
    wait_r(d, r, w, to2);
    checks++;
    if (to || to2 || d !== 32'h1122CC44) begin
      errors++;
      $display("FAIL strobe_read: got %h expected 1122cc44", d);
    end
  endtask

  task automatic test_oor;
    int c, w; bit to, to2;
    logic [1:0] r; logic [31:0] d;
    do_aw_w(32'h40, 32'h5A5A5A5A, 4'hF, 0, 2, c, to);
    wait_b(r, w, to2);
    checks++;
    if (to || to2 || r !== 2'b10) begin
      errors++;
      $display("FAIL oor_bresp: got %b expected 10", r);
    end
    do_ar(32'h40, 0, c, to);
    wait_r(d, r, w, to2);
    checks++;
    if (to || to2 || d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("FAIL oor_read: got %h/%b expected 0/10", d, r);
    end
    for (int i = 0; i < 16; i++) begin
      do_ar(32'(i * 4), 0, c, to);
      wait_r(d, r, w, to2);
      checks++;
      if (to || to2 || d !== model[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL oor_readback[%0d]: got %h/%b expected %h/00",
                 i, d, r, model[i]);
      end
    end
    do_ar(32'h0000_0006, 0, c, to);
    wait_r(d, r, w, to2);
    checks++;
    if (to || to2 || d !== model[1]) begin
      errors++;
      $display("FAIL unaligned_read: got %h expected %h", d, model[1]);
    end
  endtask

  task automatic test_backpressure;
    int c; bit to;
    logic [31:0] v;
    v = $urandom;
    BREADY = 0;
    do_aw_w(32'h10, v, 4'hF, 0, 0, c, to);
    model_wr(32'h10, v, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || BVALID !== 1'b1 || BRESP !== 2'b00 ||
          AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++;
        $display("FAIL b_stall[%0d]: got bv=%b resp=%b awr=%b wr=%b",
                 i, BVALID, BRESP, AWREADY, WREADY);
      end
      @(negedge ACLK);
    end
    BREADY = 1;
    @(negedge ACLK);
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      errors++;
      $display("FAIL b_release: got bv=%b awr=%b wr=%b expected 0/1/1",
               BVALID, AWREADY, WREADY);
    end
    RREADY = 0;
    do_ar(32'h10, 0, c, to);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || RVALID !== 1'b1 || RDATA !== v ||
          RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL r_stall[%0d]: got rv=%b data=%h expected 1/%h",
                 i, RVALID, RDATA, v);
      end
      @(negedge ACLK);
    end
    RREADY = 1;
    @(negedge ACLK);
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL r_release: got rv=%b arr=%b expected 0/1",
               RVALID, ARREADY);
    end
  endtask

  task automatic test_same_edge;
    int c1, c2, w1, w2; bit t1, t2, t3, t4;
    logic [1:0] br, rr; logic [31:0] d, old;
    old = model[3];
    fork
      begin
        do_aw_w(32'h0C, 32'h5, 4'hF, 0, 0, c1, t1);
        wait_b(br, w1, t2);
      end
      begin
        do_ar(32'h0C, 0, c2, t3);
        wait_r(d, rr, w2, t4);
      end
    join
    model_wr(32'h0C, 32'h5, 4'hF);
    checks++;
    if (t1 || t2 || t3 || t4 || c1 != 1 || c2 != 1 || d !== old) begin
      errors++;
      $display("FAIL same_edge_old: got %h (c=%0d/%0d) expected %h",
               d, c1, c2, old);
    end
    do_ar(32'h0C, 0, c2, t3);
    wait_r(d, rr, w2, t4);
    checks++;
    if (t3 || t4 || d !== 32'h5) begin
      errors++;
      $display("FAIL same_edge_new: got %h expected 00000005", d);
    end
  endtask

  task automatic test_back_to_back;
    int t0, c, w; bit to, to2;
    logic [31:0] wd [4];
    logic [31:0] rd [4];
    logic [31:0] ex [4];
    logic [1:0]  wr [4];
    bit bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ex[i] = model[12 + i];
    end
    t0 = cyc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          do_aw_w(32'((8 + i) * 4), wd[i], 4'hF, 0, 0, c, to);
          wait_b(wr[i], w, to2);
          if (to || to2) bad = 1;
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          logic [1:0] rr; int cr, wrr; bit ta, tb;
          do_ar(32'((12 + j) * 4), 0, cr, ta);
          wait_r(rd[j], rr, wrr, tb);
          if (ta || tb || rr !== 2'b00) bad = 1;
        end
      end
    join
    checks++;
    if (bad || cyc_cnt - t0 != 8) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles expected 8",
               cyc_cnt - t0);
    end
    for (int i = 0; i < 4; i++) begin
      model_wr(32'((8 + i) * 4), wd[i], 4'hF);
      checks++;
      if (rd[i] !== ex[i] || wr[i] !== 2'b00) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h/%b expected %h/00",
                 i, rd[i], wr[i], ex[i]);
      end
    end
  endtask

  task automatic test_random;
    int c, w, ad, wdl; bit to, to2;
    logic [31:0] a, d, rd;
    logic [3:0] s;
    logic [1:0] r;
    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        ad = $urandom_range(0, 3);
        wdl = $urandom_range(0, 3);
        do_aw_w(a, d, s, ad, wdl, c, to);
        wait_b(r, w, to2);
        model_wr(a, d, s);
        checks++;
        if (to || to2 || w != 0 || r !== exp_resp(a) ||
            c != ((ad > wdl) ? ad : wdl) + 1) begin
          errors++;
          $display("FAIL rand_write[%0d]: a=%h got resp=%b cyc=%0d exp %b",
                   n, a, r, c, exp_resp(a));
        end
      end else begin
        do_ar(a, $urandom_range(0, 3), c, to);
        wait_r(rd, r, w, to2);
        checks++;
        if (to || to2 || w != 0 || rd !== exp_rd(a) || r !== exp_resp(a)) begin
          errors++;
          $display("FAIL rand_read[%0d]: a=%h got %h/%b expected %h/%b",
                   n, a, rd, r, exp_rd(a), exp_resp(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int c, w; bit to, to2;
    logic [1:0] r; logic [31:0] d;
    logic [40:0] outs;
    BREADY = 0; RREADY = 0;
    do_aw_w(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, c, to);
    do_ar(32'h14, 0, c, to2);
    checks++;
    if (to || to2 || BVALID !== 1'b1 || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending: got bv=%b rv=%b expected 1/1",
               BVALID, RVALID);
    end
    #2 ARESETn = 0;
    #1;
    outs = {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA};
    checks++;
    if (outs !== 41'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0", outs);
    end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(negedge ACLK);
    ARESETn = 1; BREADY = 1; RREADY = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checks++;
      if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
        errors++;
        $display("FAIL stale_resp[%0d]: got bv=%b rv=%b expected 0/0",
                 i, BVALID, RVALID);
      end
    end
    for (int i = 0; i < 16; i++) begin
      do_ar(32'(i * 4), 0, c, to);
      wait_r(d, r, w, to2);
      checks++;
      if (to || to2 || d !== model[i] || r !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_read[%0d]: got %h/%b expected 0/00",
                 i, d, r);
      end
    end
  endtask

  initial begin
    ARESETn = 0;
    AWVALID = 0; AWADDR = '0; AWPROT = '0;
    WVALID = 0; WDATA = '0; WSTRB = '0;
    ARVALID = 0; ARADDR = '0; ARPROT = '0;
    BREADY = 1; RREADY = 1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset;
    test_basic;
    test_w_first;
    test_oor;
    test_backpressure;
    test_same_edge;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
